// File: rtl/time_frame_rx.sv
// rtl/time_frame_rx.sv - serial master-time frame receiver with delay compensation and lock tracking
//
// Purpose:
//   Deserialises framed 32-bit time words (start, D[0..31] LSB first, even parity,
//   stop) from an asynchronous serial line. It checks each frame, adds a fixed
//   propagation-delay compensation and presents the recovered time with a one-cycle
//   strobe. It also tracks link health: lock status, a saturating error count and a timeout.
//
// Ports:
//   clk          in   single clock for all logic
//   rst_n        in   asynchronous active-low reset
//   serial_in    in   asynchronous serial line, idles high
//   clr_err      in   one-cycle pulse, clears err_cnt (wins over a same-cycle increment)
//   master_time  out  last good word + DELAY_COMP
//   sync_rcvd    out  one-cycle pulse when master_time is loaded from a good frame
//   frame_err    out  one-cycle pulse on a parity or stop error
//   locked       out  LOCK_FRAMES consecutive good frames seen and no timeout since
//   err_cnt      out  saturating frame error count
//   drift        out  (TIME_FRAME_RX_TRACK_EN only) reload disagreed with free-run time
//
// Optional feature macro: TIME_FRAME_RX_TRACK_EN
//   When defined, master_time free-runs at +1 per clk and is reloaded from each good
//   frame. A reload that differs from the free-run value raises drift for one cycle.
module time_frame_rx #(
  parameter int unsigned BIT_CLKS    = 8,
  parameter logic [31:0] DELAY_COMP  = 32'd0,
  parameter int unsigned LOCK_FRAMES = 4,
  parameter logic [31:0] TIMEOUT     = 32'd200000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        serial_in,
  input  logic        clr_err,
  output logic [31:0] master_time,
  output logic        sync_rcvd,
  output logic        frame_err,
  output logic        locked,
  output logic [15:0] err_cnt
`ifdef TIME_FRAME_RX_TRACK_EN
  ,
  output logic        drift
`endif
);

  // Timer holds BIT_CLKS-1 at most, so $clog2(BIT_CLKS) bits suffice.
  localparam int          TW       = $clog2(BIT_CLKS);
  localparam logic [TW-1:0] HALF_M1  = TW'(BIT_CLKS / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(BIT_CLKS - 1);
  localparam logic [3:0]    LOCK_MAX = 4'(LOCK_FRAMES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  logic          sync1_q, s_q, s_dly_q;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [31:0]   shift_q, shift_d;
  logic          par_q, par_d;
  logic [31:0]   master_q, master_d;
  logic          sync_q, sync_d;
  logic          ferr_q, ferr_d;
  logic          locked_q, locked_d;
  logic [3:0]    lock_cnt_q, lock_cnt_d;
  logic [31:0]   tmo_q, tmo_d;
  logic [15:0]   err_q, err_d;
`ifdef TIME_FRAME_RX_TRACK_EN
  logic          have_ref_q, have_ref_d;
  logic          drift_q, drift_d;
`endif

  logic tick, good, bad;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    good      = 1'b0;
    bad       = 1'b0;
    tick      = (timer_q == '0);
    // In sampling states the timer reloads a full bit period on every sample.
    timer_d   = tick ? FULL_M1 : timer_q - 1'b1;

    case (state_q)
      IDLE: begin
        timer_d = HALF_M1;
        if (!s_q && s_dly_q) begin
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (s_q) begin
            state_d = IDLE;               // glitch: drop silently
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
            par_d     = 1'b0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = {s_q, shift_q[31:1]};
          par_d     = par_q ^ s_q;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd31) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          par_d   = par_q ^ s_q;          // zero when ones over D and P are even
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q) begin
            state_d = IDLE;
            good    = !par_q;
            bad     = par_q;
          end else begin
            state_d = BREAK;
            bad     = 1'b1;
          end
        end
      end
      BREAK: begin
        timer_d = HALF_M1;
        if (s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    sync_d = good;
    ferr_d = bad;

    if (clr_err) begin
      err_d = '0;
    end else if (bad && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end else begin
      err_d = err_q;
    end

    if (good) begin
      tmo_d = '0;
    end else if (tmo_q >= TIMEOUT) begin
      tmo_d = TIMEOUT;
    end else begin
      tmo_d = tmo_q + 32'd1;
    end

    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (bad) begin
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else if (good) begin
      lock_cnt_d = (lock_cnt_q >= LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 4'd1;
      locked_d   = (lock_cnt_d == LOCK_MAX);
    end else if (tmo_d == TIMEOUT) begin
      // Checked on the next value so locked drops exactly TIMEOUT cycles after sync_rcvd.
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end

`ifdef TIME_FRAME_RX_TRACK_EN
    master_d   = master_q + 32'd1;
    drift_d    = 1'b0;
    have_ref_d = have_ref_q | good;
    if (good) begin
      master_d = shift_q + DELAY_COMP + 32'd1;
      drift_d  = have_ref_q && ((shift_q + DELAY_COMP + 32'd1) != (master_q + 32'd1));
    end
`else
    master_d = good ? (shift_q + DELAY_COMP) : master_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      s_q        <= 1'b1;
      s_dly_q    <= 1'b1;
      state_q    <= IDLE;
      timer_q    <= HALF_M1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      master_q   <= '0;
      sync_q     <= 1'b0;
      ferr_q     <= 1'b0;
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
      tmo_q      <= '0;
      err_q      <= '0;
`ifdef TIME_FRAME_RX_TRACK_EN
      have_ref_q <= 1'b0;
      drift_q    <= 1'b0;
`endif
    end else begin
      sync1_q    <= serial_in;
      s_q        <= sync1_q;
      s_dly_q    <= s_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      master_q   <= master_d;
      sync_q     <= sync_d;
      ferr_q     <= ferr_d;
      locked_q   <= locked_d;
      lock_cnt_q <= lock_cnt_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
`ifdef TIME_FRAME_RX_TRACK_EN
      have_ref_q <= have_ref_d;
      drift_q    <= drift_d;
`endif
    end
  end

  assign master_time = master_q;
  assign sync_rcvd   = sync_q;
  assign frame_err   = ferr_q;
  assign locked      = locked_q;
  assign err_cnt     = err_q;
`ifdef TIME_FRAME_RX_TRACK_EN
  assign drift       = drift_q;
`endif

endmodule

// File: tb/tb_time_frame_rx.sv
// tb/tb_time_frame_rx.sv - scoreboard bench for time_frame_rx
module tb_time_frame_rx;

  localparam int          BIT_CLKS    = 8;
  localparam logic [31:0] DELAY_COMP  = 32'd5;
  localparam int          LOCK_FRAMES = 4;
  localparam int          TIMEOUT     = 1000;
  // Line falls -> 2 synchroniser cycles -> half bit -> 34 bits -> registered output.
  localparam int          LAT         = 2 + BIT_CLKS / 2 + 34 * BIT_CLKS + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        serial_in = 1'b1;
  logic        clr_err = 1'b0;
  logic [31:0] master_time;
  logic        sync_rcvd;
  logic        frame_err;
  logic        locked;
  logic [15:0] err_cnt;
`ifdef TIME_FRAME_RX_TRACK_EN
  logic        drift;
`endif

  time_frame_rx #(
    .BIT_CLKS   (BIT_CLKS),
    .DELAY_COMP (DELAY_COMP),
    .LOCK_FRAMES(LOCK_FRAMES),
    .TIMEOUT    (32'(TIMEOUT))
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .clr_err    (clr_err),
    .master_time(master_time),
    .sync_rcvd  (sync_rcvd),
    .frame_err  (frame_err),
    .locked     (locked),
`ifdef TIME_FRAME_RX_TRACK_EN
    .drift      (drift),
`endif
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          good;
    logic [31:0] mt;
    logic [15:0] ec;
    bit          lk;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  logic [31:0] m_mt = '0;
  logic [15:0] m_ec = '0;
  int          m_streak = 0;
  int          m_last_good = 0;
  bit          m_have_good = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per output strobe.
  always @(negedge clk) begin
    if (rst_n && (sync_rcvd || frame_err)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: sync_rcvd=%0b frame_err=%0b but nothing expected (cycle %0d)",
                 sync_rcvd, frame_err, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_sync_rcvd", 32'(sync_rcvd), 32'(mon_e.good));
        check("event_frame_err", 32'(frame_err), 32'(!mon_e.good));
        check("event_cycle", cyc, mon_e.at);
        check("event_master_time", master_time, mon_e.mt);
        check("event_err_cnt", 32'(err_cnt), 32'(mon_e.ec));
        check("event_locked", 32'(locked), 32'(mon_e.lk));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Must be called at a negedge. Pushes the expected outcome, then drives the frame.
  task automatic send_frame(input logic [31:0] d, input bit flip_par, input bit stop_bit,
                            input bit clr_at_stop, input int hold_low);
    bit [34:0] bits;
    bit        p;
    bit        good;
    exp_t      e;
    p    = (^d) ^ flip_par;
    bits = {stop_bit, p, d, 1'b0};
    good = stop_bit && !flip_par;
    e.at = cyc + LAT;
    if (good) begin
      if (m_have_good && (e.at - m_last_good > TIMEOUT)) m_streak = 0;
      m_streak    = (m_streak < LOCK_FRAMES) ? m_streak + 1 : LOCK_FRAMES;
      m_last_good = e.at;
      m_have_good = 1'b1;
      m_mt        = d + DELAY_COMP;
    end else begin
      m_streak = 0;
      if (clr_at_stop) m_ec = '0;
      else if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
    end
    e.good = good;
    e.mt   = m_mt;
    e.ec   = m_ec;
    e.lk   = (m_streak == LOCK_FRAMES);
    exp_q.push_back(e);
    for (int k = 0; k < 35; k++) begin
      serial_in = bits[k];
      for (int j = 0; j < BIT_CLKS; j++) begin
        // Place clr_err on the stop-sample cycle so it collides with the increment.
        if (clr_at_stop && k == 34) clr_err = (j == BIT_CLKS / 2 + 2);
        @(negedge clk);
      end
    end
    clr_err = 1'b0;
    repeat (hold_low) @(negedge clk);
    serial_in = 1'b1;
  endtask

  initial begin
    int last;
    logic [31:0] d;
    // Reset state
    idle(4);
    rst_n = 1'b1;
    idle(2);
    check("reset_master_time", master_time, 32'd0);
    check("reset_sync_rcvd", 32'(sync_rcvd), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);
    idle(10);

    // Good frame, then the same word with the parity bit inverted
    send_frame(32'h12345678, 1'b0, 1'b1, 1'b0, 0);
    check("good_master_time", master_time, 32'h1234567D);
    idle(BIT_CLKS + 3);
    send_frame(32'h12345678, 1'b1, 1'b1, 1'b0, 0);
    idle(3);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("clr_err_clears", 32'(err_cnt), 32'd0);
    m_ec = '0;
    idle(BIT_CLKS);

    // Start glitch: two cycles low, then a normal frame
    serial_in = 1'b0;
    idle(2);
    serial_in = 1'b1;
    idle(20);
    send_frame(32'h00000001, 1'b0, 1'b1, 1'b0, 0);
    idle(BIT_CLKS + 5);

    // Lock: an error first so the streak starts from zero, then four good frames
    send_frame(32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      idle(BIT_CLKS + i * 3);
      send_frame(32'hA5A50000 + 32'(i), 1'b0, 1'b1, 1'b0, 0);
    end
    // Timeout: locked must fall exactly TIMEOUT cycles after the last sync_rcvd
    last = m_last_good;
    while (cyc < last + TIMEOUT - 1) @(negedge clk);
    check("locked_before_timeout", 32'(locked), 32'd1);
    @(negedge clk);
    check("locked_after_timeout", 32'(locked), 32'd0);
    idle(100);

    // Wrap-around of the compensation, then a stop error with the line held low
    send_frame(32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 0);
    check("wrap_master_time", master_time, 32'h00000004);
    idle(BIT_CLKS);
    send_frame(32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, 50);
    check("break_locked", 32'(locked), 32'd0);
    idle(20);
    send_frame(32'h89ABCDEF, 1'b0, 1'b1, 1'b0, 0);
    idle(BIT_CLKS);

    // clr_err coinciding with an error increment: clear wins
    send_frame(32'h00FF00FF, 1'b0, 1'b1, 1'b0, 0);
    idle(BIT_CLKS);
    send_frame(32'h13579BDF, 1'b1, 1'b1, 1'b0, 0);
    idle(BIT_CLKS);
    send_frame(32'h2468ACE0, 1'b1, 1'b1, 1'b1, 0);
    idle(BIT_CLKS);

    // Randomised traffic with occasional parity errors
    for (int i = 0; i < 12; i++) begin
      d = $urandom;
      send_frame(d, ($urandom_range(0, 4) == 0), 1'b1, 1'b0, 0);
      idle(BIT_CLKS + $urandom_range(0, 31));
    end

    // Reset during data bit 10
    send_frame(32'h55AA55AA, 1'b1, 1'b1, 1'b0, 0);
    idle(BIT_CLKS);
    serial_in = 1'b0;
    idle(BIT_CLKS);
    for (int k = 0; k < 10; k++) begin
      serial_in = k[0];
      idle(BIT_CLKS);
    end
    serial_in = 1'b1;
    idle(3);
    rst_n = 1'b0;
    #1;
    check("midreset_master_time", master_time, 32'd0);
    check("midreset_err_cnt", 32'(err_cnt), 32'd0);
    check("midreset_locked", 32'(locked), 32'd0);
    check("midreset_sync_rcvd", 32'(sync_rcvd), 32'd0);
    m_mt = '0;
    m_ec = '0;
    m_streak = 0;
    m_have_good = 1'b0;
    idle(5);
    rst_n = 1'b1;
    idle(10);
    send_frame(32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 0);
    check("post_reset_master_time", master_time, 32'hDEADBEF4);
    idle(20);

    check("pending_events", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
